// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 character LCD drivers on the 50 MHz
// board. Both the write/initialisation driver and the read controller pull
// their bus timing from here so the two sides of the shared pins agree.
//
// Contents:
//   - timing constants in 50 MHz clock cycles (setup, E width, gaps, turn)
//   - register-select encodings RS_CMD / RS_DATA
//   - state encodings for the reader and for its nibble sub-sequencer
//   - lastCount(): terminal value for the cycle counters
// ---------------------------------------------------------------------------
package lcd_pkg;

   // Counter width used by every cycle counter in the LCD drivers. Sixteen
   // bits covers the longest wait (40 us) with plenty of room to spare.
   localparam int LCD_CNT_W = 16;

   // Bus timing at 50 MHz (20 ns per cycle).
   localparam int LCD_SETUP_CYCLES    = 2;     // RS/RW to E rise, >= 40 ns
   localparam int LCD_E_HIGH_CYCLES   = 20;    // E high width, >= 360 ns access
   localparam int LCD_GAP_1US_CYCLES  = 50;    // 1 us between nibbles
   localparam int LCD_GAP_40US_CYCLES = 2000;  // 40 us command execution
   localparam int LCD_TURN_CYCLES     = 2;     // RW held high after last E fall
   localparam int LCD_MAX_POLLS       = 1000;  // busy polls before giving up

   // Register select values.
   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_DATA = 1'b1;

   // Read controller states.
   typedef enum logic [3:0] {
      IDLE,
      MSN_SETUP,
      MSN_HIGH,
      MSN_HOLD,
      GAP,
      LSN_SETUP,
      LSN_HIGH,
      LSN_HOLD,
      TURN,
      DONE
   } readState_t;

   // Phases of a single nibble read cycle.
   typedef enum logic [1:0] {
      NB_IDLE,
      NB_SETUP,
      NB_HIGH,
      NB_HOLD
   } nibblePhase_t;

   // Counters run from zero, so a phase that lasts N cycles ends when the
   // counter shows N-1.
   function automatic logic [LCD_CNT_W-1:0] lastCount(input int cycles);
      return LCD_CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/lcd_nibble_read.sv
// ---------------------------------------------------------------------------
// lcd_nibble_read
// Runs one 4-bit read strobe on the LCD bus: SETUP cycles with E low, then
// E_HIGH cycles with E high, then one HOLD cycle with E low. The data pins
// are registered on the last E-high cycle.
//
// Ports:
//   Clock     in   system clock
//   Reset     in   synchronous, active-high
//   start     in   begin a nibble read (only honoured while idle)
//   lcdData   in   DB7..DB4 from the pad
//   enable    out  E strobe (registered)
//   phaseEnd  out  high in the last cycle of SETUP, HIGH and HOLD, so the
//                  caller can step its own state on the same edge
//   done      out  high during the HOLD cycle; nibble is valid then
//   nibble    out  sampled DB7..DB4, held until the next sample
// ---------------------------------------------------------------------------
module lcd_nibble_read
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES  = LCD_SETUP_CYCLES,
   parameter int E_HIGH_CYCLES = LCD_E_HIGH_CYCLES
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       start,
   input  logic [3:0] lcdData,
   output logic       enable,
   output logic       phaseEnd,
   output logic       done,
   output logic [3:0] nibble
);

   localparam logic [LCD_CNT_W-1:0] SETUP_LAST = lastCount(SETUP_CYCLES);
   localparam logic [LCD_CNT_W-1:0] HIGH_LAST  = lastCount(E_HIGH_CYCLES);

   nibblePhase_t          phase;
   logic [LCD_CNT_W-1:0]  count;

   // Flag the final cycle of the current phase. HOLD only ever lasts one
   // cycle, so it always ends immediately.
   always_comb begin
      phaseEnd = 1'b0;
      case (phase)
         NB_SETUP: phaseEnd = (count == SETUP_LAST);
         NB_HIGH:  phaseEnd = (count == HIGH_LAST);
         NB_HOLD:  phaseEnd = 1'b1;
         default:  phaseEnd = 1'b0;
      endcase
   end

   assign done = (phase == NB_HOLD);

   // Strobe sequencer. E is driven from a flop so it is glitch free on the
   // pad, and the pins are captured on the edge that ends the E-high window,
   // which is as late in the access as the strobe allows.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase  <= NB_IDLE;
         count  <= '0;
         enable <= 1'b0;
         nibble <= '0;
      end else begin
         case (phase)
            NB_IDLE: begin
               enable <= 1'b0;
               count  <= '0;
               if (start) begin
                  phase <= NB_SETUP;
               end
            end
            NB_SETUP: begin
               if (phaseEnd) begin
                  phase  <= NB_HIGH;
                  count  <= '0;
                  enable <= 1'b1;
               end else begin
                  count <= count + LCD_CNT_W'(1);
               end
            end
            NB_HIGH: begin
               if (phaseEnd) begin
                  phase  <= NB_HOLD;
                  count  <= '0;
                  enable <= 1'b0;
                  nibble <= lcdData;
               end else begin
                  count <= count + LCD_CNT_W'(1);
               end
            end
            NB_HOLD: begin
               phase <= NB_IDLE;
               count <= '0;
            end
            default: begin
               phase  <= NB_IDLE;
               count  <= '0;
               enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader
// 4-bit read controller for the HD44780 character LCD. Performs a status
// read (RS=0: busy flag + address counter) or a data read (RS=1) as two
// nibble strobes with RW=1. In poll mode it keeps re-reading status until
// the busy flag clears or the poll limit is reached.
//
// Ports:
//   Clock         in   system clock, 50 MHz
//   Reset         in   synchronous, active-high
//   iStart        in   request a read; sampled only when ready=1
//   iRS           in   0 = status read, 1 = data read
//   iPoll         in   repeat status reads until BF=0 (forces RS=0)
//   iLCD_Data     in   DB7..DB4 from the pad
//   oLCD_Enabled  out  E strobe
//   oLCD_RS       out  register select
//   oLCD_RW       out  1 = read
//   oLCD_DataOE   out  1 = FPGA may drive DB7..DB4, 0 = bus left to the LCD
//   oData         out  assembled byte {MSN,LSN}, held until next oValid
//   oValid        out  one-cycle pulse when oData updates
//   oTimeout      out  one-cycle pulse with oValid when polling gave up
//   ready         out  idle and accepting iStart
// ---------------------------------------------------------------------------
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES  = LCD_SETUP_CYCLES,
   parameter int E_HIGH_CYCLES = LCD_E_HIGH_CYCLES,
   parameter int NIBBLE_GAP    = LCD_GAP_1US_CYCLES,
   parameter int TURN_CYCLES   = LCD_TURN_CYCLES,
   parameter int MAX_POLLS     = LCD_MAX_POLLS
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iStart,
   input  logic       iRS,
   input  logic       iPoll,
   input  logic [3:0] iLCD_Data,
   output logic       oLCD_Enabled,
   output logic       oLCD_RS,
   output logic       oLCD_RW,
   output logic       oLCD_DataOE,
   output logic [7:0] oData,
   output logic       oValid,
   output logic       oTimeout,
   output logic       ready
);

   localparam int POLL_W = $clog2(MAX_POLLS) + 1;

   localparam logic [LCD_CNT_W-1:0] GAP_LAST  = lastCount(NIBBLE_GAP);
   localparam logic [LCD_CNT_W-1:0] TURN_LAST = lastCount(TURN_CYCLES);
   localparam logic [POLL_W-1:0]    POLL_LAST = POLL_W'(MAX_POLLS - 1);

   readState_t            state;
   logic [LCD_CNT_W-1:0]  count;
   logic [POLL_W-1:0]     pollCount;
   logic                  pollMode;
   logic                  gapToMsn;
   logic [7:0]            shadowByte;
   logic                  accept;
   logic                  pollAgain;
   logic                  nbStart;
   logic                  nbPhaseEnd;
   logic                  nbDone;
   logic [3:0]            nbNibble;

   // A request is only taken once the post-reset / post-read idle cycle has
   // raised ready, so a start held across reset cannot sneak in.
   assign accept = (state == IDLE) && ready && iStart;

   // Another status read is needed while the busy flag (MSN bit 3 of the
   // read just finished) is still set and the poll budget is not spent.
   assign pollAgain = pollMode && shadowByte[7] && (pollCount < POLL_LAST);

   // The nibble sequencer is kicked on the same edge that moves this FSM
   // into a SETUP state, so both stay in lock-step.
   assign nbStart = accept || ((state == GAP) && (count == GAP_LAST));

   // One strobe engine serves both nibbles of every read.
   lcd_nibble_read #(
      .SETUP_CYCLES  (SETUP_CYCLES),
      .E_HIGH_CYCLES (E_HIGH_CYCLES)
   ) nibbleRead (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (nbStart),
      .lcdData  (iLCD_Data),
      .enable   (oLCD_Enabled),
      .phaseEnd (nbPhaseEnd),
      .done     (nbDone),
      .nibble   (nbNibble)
   );

   // Main read sequencer. All pad-facing outputs are registered here. OE is
   // dropped on the same edge RW rises and only re-raised a cycle after the
   // FSM is back in IDLE with RW low, so the FPGA never drives DB while the
   // LCD might. The byte is assembled in shadowByte and copied to oData in
   // one go so consumers never see half of a read.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         count        <= '0;
         pollCount    <= '0;
         pollMode     <= 1'b0;
         gapToMsn     <= 1'b0;
         shadowByte   <= '0;
         oLCD_RS      <= 1'b0;
         oLCD_RW      <= 1'b0;
         oLCD_DataOE  <= 1'b0;
         oData        <= '0;
         oValid       <= 1'b0;
         oTimeout     <= 1'b0;
         ready        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (accept) begin
                  state       <= MSN_SETUP;
                  oLCD_RS     <= iPoll ? RS_CMD : iRS;
                  pollMode    <= iPoll;
                  pollCount   <= '0;
                  gapToMsn    <= 1'b0;
                  oLCD_RW     <= 1'b1;
                  oLCD_DataOE <= 1'b0;
                  ready       <= 1'b0;
               end else begin
                  oLCD_DataOE <= 1'b1;
                  ready       <= 1'b1;
               end
            end
            MSN_SETUP: begin
               if (nbPhaseEnd) begin
                  state <= MSN_HIGH;
               end
            end
            MSN_HIGH: begin
               if (nbPhaseEnd) begin
                  state <= MSN_HOLD;
               end
            end
            MSN_HOLD: begin
               if (nbDone) begin
                  shadowByte[7:4] <= nbNibble;
                  gapToMsn        <= 1'b0;
                  count           <= '0;
                  state           <= GAP;
               end
            end
            GAP: begin
               if (count == GAP_LAST) begin
                  count <= '0;
                  state <= gapToMsn ? MSN_SETUP : LSN_SETUP;
               end else begin
                  count <= count + LCD_CNT_W'(1);
               end
            end
            LSN_SETUP: begin
               if (nbPhaseEnd) begin
                  state <= LSN_HIGH;
               end
            end
            LSN_HIGH: begin
               if (nbPhaseEnd) begin
                  state <= LSN_HOLD;
               end
            end
            LSN_HOLD: begin
               if (nbDone) begin
                  shadowByte[3:0] <= nbNibble;
                  count           <= '0;
                  if (pollAgain) begin
                     pollCount <= pollCount + POLL_W'(1);
                     gapToMsn  <= 1'b1;
                     state     <= GAP;
                  end else begin
                     state <= TURN;
                  end
               end
            end
            TURN: begin
               if (count == TURN_LAST) begin
                  count    <= '0;
                  oLCD_RW  <= 1'b0;
                  oData    <= shadowByte;
                  oValid   <= 1'b1;
                  oTimeout <= pollMode && shadowByte[7];
                  state    <= DONE;
               end else begin
                  count <= count + LCD_CNT_W'(1);
               end
            end
            DONE: begin
               oValid   <= 1'b0;
               oTimeout <= 1'b0;
               ready    <= 1'b1;
               count    <= '0;
               state    <= IDLE;
            end
            default: begin
               state       <= IDLE;
               count       <= '0;
               oLCD_RW     <= 1'b0;
               oLCD_DataOE <= 1'b0;
               oValid      <= 1'b0;
               oTimeout    <= 1'b0;
               ready       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_reader
// Directed bench for lcd_reader. A small LCD model answers each E pulse
// with the next nibble of a scripted byte list; every cycle is sampled on
// the falling clock edge and reduced to a few statistics that are compared
// against hand-computed values.
// Cycle numbering: cycle N is the period following the edge at which the
// request was sampled N-1 edges earlier (request sampled at edge 0 gives
// RW high in cycle 1).
// ---------------------------------------------------------------------------
module tb_lcd_reader;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       iStart = 1'b0;
   logic       iRS = 1'b0;
   logic       iPoll = 1'b0;
   logic [3:0] iLCD_Data = 4'h0;
   logic       oLCD_Enabled;
   logic       oLCD_RS;
   logic       oLCD_RW;
   logic       oLCD_DataOE;
   logic [7:0] oData;
   logic       oValid;
   logic       oTimeout;
   logic       ready;

   lcd_reader #(.MAX_POLLS(4)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iStart       (iStart),
      .iRS          (iRS),
      .iPoll        (iPoll),
      .iLCD_Data    (iLCD_Data),
      .oLCD_Enabled (oLCD_Enabled),
      .oLCD_RS      (oLCD_RS),
      .oLCD_RW      (oLCD_RW),
      .oLCD_DataOE  (oLCD_DataOE),
      .oData        (oData),
      .oValid       (oValid),
      .oTimeout     (oTimeout),
      .ready        (ready)
   );

   // 50 MHz clock.
   always #10 Clock = ~Clock;

   int checks = 0;
   int failures = 0;

   // LCD model state and scripted responses.
   logic [7:0] respBytes [8];
   int         respLen;
   int         respIdx;
   logic       nibSel;
   logic       prevE = 1'b0;

   // Per-read statistics.
   int         cycle;
   int         rwFirst, rwLast, eRise0, eRise1, eLastHigh, eHighCount;
   int         rsHighCount, msnPulses, validCount, validCycle, timeoutCount;
   int         timeoutCycle, readyCycle, overlapCount;
   logic [7:0] lastData;

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Clear the statistics and rewind the LCD model for a new read.
   task automatic clearStats();
      cycle = 0; rwFirst = -1; rwLast = -1; eRise0 = -1; eRise1 = -1;
      eLastHigh = -1; eHighCount = 0; rsHighCount = 0; msnPulses = 0;
      validCount = 0; validCycle = -1; timeoutCount = 0; timeoutCycle = -1;
      readyCycle = -1; respIdx = 0; nibSel = 1'b0;
   endtask

   // Advance one clock, then sample the DUT, record statistics and let the
   // LCD model present the nibble for any new E pulse.
   task automatic runCycle();
      logic [7:0] cur;
      @(negedge Clock);
      cycle++;
      if (oLCD_RW && oLCD_DataOE) overlapCount++;
      if (oLCD_RW) begin
         if (rwFirst < 0) rwFirst = cycle;
         rwLast = cycle;
         if (oLCD_RS) rsHighCount++;
      end
      if (oLCD_Enabled) begin
         eHighCount++;
         eLastHigh = cycle;
      end
      if (oValid) begin
         validCount++;
         validCycle = cycle;
         lastData = oData;
      end
      if (oTimeout) begin
         timeoutCount++;
         timeoutCycle = cycle;
      end
      if (ready && validCount > 0 && readyCycle < 0) readyCycle = cycle;
      if (oLCD_Enabled && !prevE) begin
         if (eRise0 < 0) eRise0 = cycle;
         else if (eRise1 < 0) eRise1 = cycle;
         cur = respBytes[respIdx];
         if (!nibSel) begin
            iLCD_Data = cur[7:4];
            msnPulses++;
            nibSel = 1'b1;
         end else begin
            iLCD_Data = cur[3:0];
            nibSel = 1'b0;
            if (respIdx < respLen - 1) respIdx++;
         end
      end
      prevE = oLCD_Enabled;
   endtask

   // Issue a read request sampled at edge 0.
   task automatic applyStimulus(input logic rs, input logic poll);
      clearStats();
      iStart = 1'b1;
      iRS = rs;
      iPoll = poll;
      runCycle();
      iStart = 1'b0;
   endtask

   // Run until the DUT is ready again after delivering a byte.
   task automatic runRead(input string tag, input int budget);
      while (readyCycle < 0 && cycle < budget) runCycle();
      checkOutput({tag, "_completed"}, (readyCycle >= 0), 1'b1);
   endtask

   initial begin
      overlapCount = 0;
      respLen = 1;
      respBytes[0] = 8'h00;
      clearStats();

      // Reset state.
      repeat (3) runCycle();
      checkOutput("reset_outputs",
                  {oLCD_Enabled, oLCD_RS, oLCD_RW, oLCD_DataOE, oValid, oTimeout, ready},
                  7'b0);
      checkOutput("reset_data", oData, 8'h00);
      Reset = 1'b0;
      runCycle();
      checkOutput("idle_ready_oe", {ready, oLCD_DataOE, oLCD_RW}, 3'b110);

      // Data read returning A5.
      respBytes[0] = 8'hA5; respLen = 1;
      applyStimulus(1'b1, 1'b0);
      runRead("data", 150);
      checkOutput("data_rw_first", rwFirst, 1);
      checkOutput("data_rw_last", rwLast, 98);
      checkOutput("data_e_rise_msn", eRise0, 3);
      checkOutput("data_e_rise_lsn", eRise1, 76);
      checkOutput("data_e_last_high", eLastHigh, 95);
      checkOutput("data_e_high_count", eHighCount, 40);
      checkOutput("data_rs_high", rsHighCount, 98);
      checkOutput("data_valid_cycle", validCycle, 99);
      checkOutput("data_valid_count", validCount, 1);
      checkOutput("data_byte", lastData, 8'hA5);
      checkOutput("data_ready_cycle", readyCycle, 100);
      runCycle();
      checkOutput("data_oe_after_idle", {oLCD_DataOE, oData}, {1'b1, 8'hA5});

      // Status read returning 4F.
      respBytes[0] = 8'h4F; respLen = 1;
      applyStimulus(1'b0, 1'b0);
      runRead("status", 150);
      checkOutput("status_rs_high", rsHighCount, 0);
      checkOutput("status_byte", lastData, 8'h4F);
      checkOutput("status_timeout", timeoutCount, 0);
      runCycle();

      // Poll: busy for three reads, then 07. RS forced to 0 despite iRS=1.
      respBytes[0] = 8'h8A; respBytes[1] = 8'h9B; respBytes[2] = 8'hC0;
      respBytes[3] = 8'h07; respLen = 4;
      applyStimulus(1'b1, 1'b1);
      runRead("poll", 800);
      checkOutput("poll_msn_pulses", msnPulses, 4);
      checkOutput("poll_valid_count", validCount, 1);
      checkOutput("poll_valid_cycle", validCycle, 99 + 3 * 146);
      checkOutput("poll_byte", lastData, 8'h07);
      checkOutput("poll_timeout", timeoutCount, 0);
      checkOutput("poll_rs_high", rsHighCount, 0);
      runCycle();

      // Poll limit: always busy, limit of 4 reads.
      respBytes[0] = 8'h80; respLen = 1;
      applyStimulus(1'b0, 1'b1);
      runRead("limit", 800);
      checkOutput("limit_msn_pulses", msnPulses, 4);
      checkOutput("limit_valid_count", validCount, 1);
      checkOutput("limit_timeout_count", timeoutCount, 1);
      checkOutput("limit_timeout_with_valid", timeoutCycle, validCycle);
      checkOutput("limit_byte", lastData, 8'h80);
      runCycle();

      // Reset in cycle 40 (during GAP) aborts the read.
      respBytes[0] = 8'h5A; respLen = 1;
      applyStimulus(1'b1, 1'b0);
      while (cycle < 40) runCycle();
      Reset = 1'b1;
      runCycle();
      checkOutput("abort_pins", {oLCD_Enabled, oLCD_RW, oLCD_DataOE, oValid, ready}, 5'b0);
      Reset = 1'b0;
      runCycle();
      checkOutput("abort_idle_oe", {ready, oLCD_DataOE, oLCD_RW}, 3'b110);
      repeat (120) runCycle();
      checkOutput("abort_no_valid", validCount, 0);
      respBytes[0] = 8'h3C; respLen = 1;
      applyStimulus(1'b1, 1'b0);
      runRead("after_abort", 150);
      checkOutput("after_abort_byte", lastData, 8'h3C);
      checkOutput("after_abort_valid_cycle", validCycle, 99);
      runCycle();

      // iStart pulsed in cycle 50 of an active read is ignored.
      respBytes[0] = 8'hC3; respLen = 1;
      applyStimulus(1'b1, 1'b0);
      while (cycle < 50) runCycle();
      iStart = 1'b1;
      runCycle();
      iStart = 1'b0;
      runRead("ignore", 150);
      checkOutput("ignore_byte", lastData, 8'hC3);
      checkOutput("ignore_valid_cycle", validCycle, 99);
      repeat (150) runCycle();
      checkOutput("ignore_valid_count", validCount, 1);
      checkOutput("ignore_rw_last", rwLast, 98);

      checkOutput("no_rw_oe_overlap", overlapCount, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- 4-bit read controller for the HD44780-compatible character LCD on the 50 MHz board. It is the read-side counterpart of the existing LCD write/initialisation driver.
- Performs status reads (RS=0: busy flag + address counter) and data reads (RS=1: DDRAM/CGRAM byte) by running two nibble read cycles with RW=1.
- Optional poll mode repeats status reads until BF=0, so the top level can wait on busy instead of on fixed delays.
- Shares the LCD pins with the write driver; the top-level mux selects by `ready` and `oLCD_DataOE`.

Parameters:
- SETUP_CYCLES, 2, cycles RS/RW stable before E rises (>=40 ns)
- E_HIGH_CYCLES, 20, E high width; data sampled on last high cycle (>=360 ns access)
- NIBBLE_GAP, 50, E-low cycles between MSN and LSN (1 us)
- TURN_CYCLES, 2, cycles RW held 1 after final E fall before bus returned
- MAX_POLLS, 1000, status reads allowed in poll mode before timeout

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- iStart  in  1  request a read; sampled only when ready=1
- iRS  in  1  0=status read, 1=data read; latched with iStart
- iPoll  in  1  repeat status reads until BF=0; forces RS=0; latched with iStart
- iLCD_Data  in  4  LCD DB7..DB4 from the pad
- oLCD_Enabled  out  1  E strobe
- oLCD_RS  out  1  register select
- oLCD_RW  out  1  1 = read
- oLCD_DataOE  out  1  1 = FPGA may drive DB7..DB4; 0 = released to the LCD
- oData  out  8  assembled byte {MSN,LSN}; holds until the next oValid
- oValid  out  1  one-cycle pulse when oData is updated
- oTimeout  out  1  one-cycle pulse with oValid when the poll limit is hit
- ready  out  1  idle, accepting iStart

Behaviour:
- Reset values: oLCD_Enabled=0, oLCD_RS=0, oLCD_RW=0, oLCD_DataOE=0, oData=0, oValid=0, oTimeout=0, ready=0. State goes to IDLE.
- ready=1 only in IDLE. oLCD_DataOE rises one cycle after IDLE is entered with RW=0, so there is never a cycle with RW=1 and OE=1.
- Reset mid-transaction aborts on the next edge: E=0, RW=0, OE=0, and no oValid.
- States: IDLE, MSN_SETUP, MSN_HIGH, MSN_HOLD, GAP, LSN_SETUP, LSN_HIGH, LSN_HOLD, TURN, DONE. One shared down/up counter, cleared on every state change.
- IDLE:
  - If iStart=1: latch RS (0 if iPoll) and iPoll.
  - Drive OE=0, RW=1, RS=latched value.
  - Go to MSN_SETUP.
  - iStart while ready=0 is ignored.
- *_SETUP: E=0 for SETUP_CYCLES cycles.
- *_HIGH: E=1 for E_HIGH_CYCLES cycles. iLCD_Data is registered on the last cycle, into [7:4] for MSN and [3:0] for LSN.
- *_HOLD: 1 cycle, E=0, RS and RW unchanged.
- GAP: NIBBLE_GAP cycles, E=0, RW=1.
- After LSN_HOLD:
  - If poll mode and MSN[3] (BF)=1 and poll count < MAX_POLLS-1: increment poll count and go to GAP → MSN_SETUP.
  - Otherwise go to TURN.
- TURN: TURN_CYCLES cycles with RW=1 and E=0, then RW=0.
- DONE: 1 cycle. oData updated, oValid=1. oTimeout=1 if the last read still had BF=1 in poll mode. Return to IDLE.
- Single-read latency with defaults: iStart sampled at edge 0 → oValid high in cycle 99 → ready=1 in cycle 100.
- Each extra poll iteration adds 2+20+1+50+2+20+1+50 = 146 cycles.
- oData is never partially updated. The byte is assembled in a shadow register and copied in DONE.

Decomposition:
- Shared package lcd_pkg holds:
  - state encodings for the reader;
  - 50 MHz timing constants (E width, setup, 1 us and 40 us gaps), shared with the write driver;
  - RS_CMD/RS_DATA constants.
- One sub-module, lcd_nibble_read: runs setup/high/hold for a single nibble, with start/done handshake and a 4-bit sampled output. It is instantiated once and reused for MSN and LSN.

Test Plan:
- Data read, iRS=1, LCD model returns 8'hA5 → RW=1 from cycle 1 to 98; E high in cycles 3-22 and 76-95; oData=8'hA5 with oValid in cycle 99; ready=1 in cycle 100.
- Status read, iRS=0, model returns 8'h4F → oLCD_RS=0 throughout; oData=8'h4F; oTimeout=0.
- Poll, model returns BF=1 for 3 reads then 8'h07 → exactly 4 MSN E pulses; oValid once with oData=8'h07; oTimeout=0.
- Poll with MAX_POLLS=4 and BF always 1 (8'h80) → 4 reads; oValid and oTimeout together; oData=8'h80.
- Reset asserted in cycle 40 (during GAP) → next cycle E=0, RW=0, OE=0, no oValid; after release, OE=1 one cycle after IDLE; a new read completes normally.
- iStart pulsed in cycle 50 of an active read → ignored; exactly one oValid.
